// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART receiver.
// Holds the FSM and parity encodings, the 3-sample vote and the bit-period helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign rdata     = empty ? '0 : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer and storage update.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r                <= wr_ptr_r + PTR_INC;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_INC;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: 2-flop synchroniser, mid-bit 3-sample vote, configurable
// data/parity/stop format, FWFT output FIFO and framing/overrun pulses.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int DATA_WIDTH       = 8,
  parameter int PARITY_MODE      = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rx_wire_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  parity_err_out,
  output logic                  data_valid_out,
  input  logic                  data_ready_in,
  output logic                  framing_err_out,
  output logic                  overrun_out,
  output logic                  busy_out
);

  localparam int CPB   = clks_per_bit(INPUT_CLOCK_FREQ, BAUD_RATE);
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_EN   = (PARITY_MODE != int'(PAR_NONE));
  localparam logic             ODD_MODE = (PARITY_MODE == int'(PAR_ODD));

  rx_state_t             state_r;
  rx_state_t             state_next;
  logic                  sync1_r;
  logic                  sync2_r;
  logic                  rx_s;
  logic [CNT_W-1:0]      cnt_r;
  logic                  s0_r;
  logic                  s1_r;
  logic                  vote_s;
  logic                  at_vote_s;
  logic                  at_end_s;
  logic [DATA_WIDTH-1:0] shreg_r;
  logic [IDX_W-1:0]      bit_idx_r;
  logic                  stop_idx_r;
  logic                  par_err_r;
  logic                  start_s;
  logic                  shift_s;
  logic                  par_cap_s;
  logic                  idx_inc_s;
  logic                  stop_inc_s;
  logic                  push_s;
  logic                  ferr_s;
  logic                  ferr_r;
  logic                  ovr_r;
  logic                  busy_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  pop_s;
  logic [DATA_WIDTH:0]   head_s;

  assign rx_s      = sync2_r;
  assign vote_s    = majority3(s0_r, s1_r, rx_s);
  assign at_vote_s = (cnt_r == CNT_VOTE);
  assign at_end_s  = (cnt_r == CNT_LAST);

  // Line synchroniser, bit timer and mid-bit sample capture.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      cnt_r   <= '0;
      s0_r    <= 1'b1;
      s1_r    <= 1'b1;
    end else begin
      sync1_r <= rx_wire_in;
      sync2_r <= sync1_r;
      if (state_r == IDLE || at_end_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      s0_r <= (cnt_r == CNT_S0) ? rx_s : s0_r;
      s1_r <= (cnt_r == CNT_S1) ? rx_s : s1_r;
    end
  end

  // Next-state and datapath strobes; every decision point is a timer count.
  always_comb begin
    state_next = state_r;
    start_s    = 1'b0;
    shift_s    = 1'b0;
    par_cap_s  = 1'b0;
    idx_inc_s  = 1'b0;
    stop_inc_s = 1'b0;
    push_s     = 1'b0;
    ferr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          start_s    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (at_vote_s && vote_s) begin
          state_next = IDLE;
        end else if (at_end_s) begin
          state_next = DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        shift_s = at_vote_s;
        if (at_end_s && (bit_idx_r == IDX_LAST)) begin
          if (PAR_EN) begin
            state_next = PARITY;
          end else begin
            state_next = STOP;
          end
        end else if (at_end_s) begin
          idx_inc_s = 1'b1;
        end else begin
          state_next = DATA;
        end
      end
      PARITY: begin
        par_cap_s = at_vote_s;
        if (at_end_s) begin
          state_next = STOP;
        end else begin
          state_next = PARITY;
        end
      end
      STOP: begin
        // Push at the last stop-bit midpoint to leave half a bit of resync margin.
        if (at_vote_s && !vote_s) begin
          ferr_s     = 1'b1;
          state_next = BREAK;
        end else if (at_vote_s && (stop_idx_r == STOP_LAST)) begin
          push_s     = 1'b1;
          state_next = IDLE;
        end else if (at_end_s) begin
          stop_inc_s = 1'b1;
        end else begin
          state_next = STOP;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end else begin
          state_next = BREAK;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, frame assembly and registered status pulses.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      bit_idx_r  <= '0;
      stop_idx_r <= 1'b0;
      par_err_r  <= 1'b0;
      ferr_r     <= 1'b0;
      ovr_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_next;
      shreg_r <= shift_s ? {vote_s, shreg_r[DATA_WIDTH-1:1]} : shreg_r;
      if (start_s) begin
        bit_idx_r  <= '0;
        stop_idx_r <= 1'b0;
        par_err_r  <= 1'b0;
      end else begin
        bit_idx_r  <= idx_inc_s ? (bit_idx_r + IDX_ONE) : bit_idx_r;
        stop_idx_r <= stop_inc_s ? 1'b1 : stop_idx_r;
        par_err_r  <= par_cap_s ? (((^shreg_r) ^ vote_s) != ODD_MODE) : par_err_r;
      end
      ferr_r <= ferr_s;
      ovr_r  <= push_s && full_s && !pop_s;
      busy_r <= (state_next != IDLE);
    end
  end

  assign pop_s = !empty_s && data_ready_in;

  uart_rx_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (push_s),
    .wdata    ({par_err_r, shreg_r}),
    .pop      (pop_s),
    .rdata    (head_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  assign data_out        = head_s[DATA_WIDTH-1:0];
  assign parity_err_out  = head_s[DATA_WIDTH];
  assign data_valid_out  = !empty_s;
  assign framing_err_out = ferr_r;
  assign overrun_out     = ovr_r;
  assign busy_out        = busy_r;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Self-checking bench: three receiver configurations (8N1, 8E1, 7O2) driven at
// 16 clocks/bit and compared against a frame-level model of the line protocol.
module tb_uart_rx_framed;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       rx_a = 1'b1, rdy_a = 1'b1;
  logic [7:0] dat_a;
  logic       perr_a, vld_a, ferr_a, ovr_a, busy_a;
  logic       rx_p = 1'b1, rdy_p = 1'b1;
  logic [7:0] dat_p;
  logic       perr_p, vld_p, ferr_p, ovr_p, busy_p;
  logic       rx_m = 1'b1, rdy_m = 1'b1;
  logic [6:0] dat_m;
  logic       perr_m, vld_m, ferr_m, ovr_m, busy_m;

  uart_rx_framed #(.INPUT_CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
                   .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n), .rx_wire_in(rx_a), .data_out(dat_a),
    .parity_err_out(perr_a), .data_valid_out(vld_a), .data_ready_in(rdy_a),
    .framing_err_out(ferr_a), .overrun_out(ovr_a), .busy_out(busy_a));

  uart_rx_framed #(.INPUT_CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
                   .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
    .clk_in(clk_in), .rst_n_in(rst_n), .rx_wire_in(rx_p), .data_out(dat_p),
    .parity_err_out(perr_p), .data_valid_out(vld_p), .data_ready_in(rdy_p),
    .framing_err_out(ferr_p), .overrun_out(ovr_p), .busy_out(busy_p));

  uart_rx_framed #(.INPUT_CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(7),
                   .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_m (
    .clk_in(clk_in), .rst_n_in(rst_n), .rx_wire_in(rx_m), .data_out(dat_m),
    .parity_err_out(perr_m), .data_valid_out(vld_m), .data_ready_in(rdy_m),
    .framing_err_out(ferr_m), .overrun_out(ovr_m), .busy_out(busy_m));

  int checks = 0;
  int errors = 0;

  logic [8:0] dq_a[$], dq_p[$], dq_m[$];
  logic       fq_a[$], fq_p[$], fq_m[$];
  int         fe_n[3];
  int         ov_n[3];
  int         vc_a;

  // Observer: records every accepted FIFO head and counts status pulses.
  always @(negedge clk_in) begin
    if (vld_a && rdy_a) begin dq_a.push_back(9'(dat_a)); fq_a.push_back(perr_a); end
    if (vld_p && rdy_p) begin dq_p.push_back(9'(dat_p)); fq_p.push_back(perr_p); end
    if (vld_m && rdy_m) begin dq_m.push_back(9'(dat_m)); fq_m.push_back(perr_m); end
    if (vld_a) vc_a++;
    if (ferr_a) fe_n[0]++;
    if (ferr_p) fe_n[1]++;
    if (ferr_m) fe_n[2]++;
    if (ovr_a) ov_n[0]++;
    if (ovr_p) ov_n[1]++;
    if (ovr_m) ov_n[2]++;
  end

  // Reference model: parity bit that makes a frame correct.
  function automatic logic good_parity(input logic [8:0] d, input int nbits, input int mode);
    int ones;
    ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(d[i]);
    return (mode == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic clear_mon();
    dq_a.delete(); dq_p.delete(); dq_m.delete();
    fq_a.delete(); fq_p.delete(); fq_m.delete();
    fe_n = '{0, 0, 0};
    ov_n = '{0, 0, 0};
    vc_a = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic set_line(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_p = v;
      default: rx_m = v;
    endcase
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk_in);
    #1 rdy_a = v;
  endtask

  // Serialise one frame LSB-first; corrupt flips one clock near each bit's midpoint.
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int pmode, input logic p, input int nstop,
                            input logic last_stop, input logic corrupt);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (pmode != 0) bits.push_back(p);
    for (int i = 0; i < nstop; i++) bits.push_back((i == nstop - 1) ? last_stop : 1'b1);
    foreach (bits[b]) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk_in);
        set_line(which, bits[b] ^ (corrupt && (c == 9)));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++; if (dat_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", dat_a); end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", vld_a); end
    checks++; if (perr_a !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", perr_a); end
    checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", ferr_a); end
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", ovr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    clear_mon();
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    idle(8);
    checks++; if (dq_a.size() != 1 || dq_a[0] !== 9'h0A5)
      begin errors++; $display("FAIL basic_data: got %0d words, first %h, expected 1 word a5", dq_a.size(), (dq_a.size() > 0) ? dq_a[0] : 9'h1FF); end
    checks++; if (vc_a != 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 1", vc_a); end
    checks++; if (fq_a.size() != 1 || fq_a[0] !== 1'b0) begin errors++; $display("FAIL basic_perr: flag not 0"); end
    checks++; if (fe_n[0] != 0 || ov_n[0] != 0)
      begin errors++; $display("FAIL basic_pulses: ferr %0d ovr %0d expected 0 0", fe_n[0], ov_n[0]); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy_a); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    logic [8:0] d;
    clear_mon();
    for (int k = 0; k < 6; k++) begin
      d = 9'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(0, d, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    end
    idle(8);
    checks++; if (dq_a.size() != exp_q.size())
      begin errors++; $display("FAIL b2b_count: got %0d expected %0d", dq_a.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      checks++; if (k >= dq_a.size() || dq_a[k] !== exp_q[k])
        begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, (k < dq_a.size()) ? dq_a[k] : 9'h1FF, exp_q[k]); end
    end
  endtask

  task automatic test_parity();
    logic [8:0] d[$];
    logic       p[$];
    logic       ef[$];
    clear_mon();
    d.push_back(9'h003); p.push_back(1'b0);
    d.push_back(9'h003); p.push_back(1'b1);
    for (int k = 0; k < 4; k++) begin
      d.push_back(9'($urandom_range(0, 255)));
      p.push_back(1'($urandom_range(0, 1)));
    end
    foreach (d[k]) begin
      ef.push_back(p[k] != good_parity(d[k], 8, 2));
      send_frame(1, d[k], 8, 2, p[k], 1, 1'b1, 1'b0);
    end
    idle(8);
    checks++; if (dq_p.size() != d.size())
      begin errors++; $display("FAIL parity_count: got %0d expected %0d", dq_p.size(), d.size()); end
    foreach (d[k]) begin
      checks++; if (k >= dq_p.size() || dq_p[k] !== d[k] || fq_p[k] !== ef[k])
        begin errors++; $display("FAIL parity_word[%0d]: got %h/%b expected %h/%b", k,
          (k < dq_p.size()) ? dq_p[k] : 9'h1FF, (k < fq_p.size()) ? fq_p[k] : 1'bx, d[k], ef[k]); end
    end
    checks++; if (fe_n[1] != 0) begin errors++; $display("FAIL parity_ferr: got %0d expected 0", fe_n[1]); end
  endtask

  task automatic test_noise();
    clear_mon();
    for (int c = 0; c < 4; c++) begin @(negedge clk_in); rx_a = 1'b0; end
    @(negedge clk_in); rx_a = 1'b1;
    idle(40);
    checks++; if (dq_a.size() != 0 || fe_n[0] != 0)
      begin errors++; $display("FAIL glitch: words %0d ferr %0d expected 0 0", dq_a.size(), fe_n[0]); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy_a); end
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    idle(8);
    checks++; if (dq_a.size() != 1 || dq_a[0] !== 9'h03C)
      begin errors++; $display("FAIL vote_recover: got %0d words, first %h, expected 3c", dq_a.size(), (dq_a.size() > 0) ? dq_a[0] : 9'h1FF); end
  endtask

  task automatic test_framing();
    clear_mon();
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b0, 1'b0);
    @(negedge clk_in); rx_a = 1'b1;
    idle(40);
    checks++; if (fe_n[0] != 1) begin errors++; $display("FAIL framing_pulse: got %0d expected 1", fe_n[0]); end
    checks++; if (dq_a.size() != 0) begin errors++; $display("FAIL framing_push: got %0d words expected 0", dq_a.size()); end
    clear_mon();
    for (int c = 0; c < 50 * 16; c++) begin @(negedge clk_in); rx_a = 1'b0; end
    @(negedge clk_in); rx_a = 1'b1;
    idle(32);
    send_frame(0, 9'h055, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    idle(8);
    checks++; if (fe_n[0] != 1) begin errors++; $display("FAIL break_pulse: got %0d expected 1", fe_n[0]); end
    checks++; if (dq_a.size() != 1 || dq_a[0] !== 9'h055)
      begin errors++; $display("FAIL break_recover: got %0d words, first %h, expected 55", dq_a.size(), (dq_a.size() > 0) ? dq_a[0] : 9'h1FF); end
  endtask

  task automatic test_overrun();
    clear_mon();
    set_ready(1'b0);
    for (int k = 1; k <= 4; k++) send_frame(0, 9'(k), 8, 0, 1'b0, 1, 1'b1, 1'b0);
    idle(8);
    checks++; if (ov_n[0] != 0 || vld_a !== 1'b1)
      begin errors++; $display("FAIL overrun_early: ovr %0d valid %b expected 0 1", ov_n[0], vld_a); end
    send_frame(0, 9'h005, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    idle(8);
    checks++; if (ov_n[0] != 1) begin errors++; $display("FAIL overrun_pulse: got %0d expected 1", ov_n[0]); end
    set_ready(1'b1);
    idle(10);
    checks++; if (dq_a.size() != 4) begin errors++; $display("FAIL overrun_drain_count: got %0d expected 4", dq_a.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (k >= dq_a.size() || dq_a[k] !== 9'(k + 1))
        begin errors++; $display("FAIL overrun_drain[%0d]: got %h expected %h", k, (k < dq_a.size()) ? dq_a[k] : 9'h1FF, 9'(k + 1)); end
    end
  endtask

  task automatic test_modes();
    logic [8:0] d[$];
    logic       p[$];
    logic       ef[$];
    clear_mon();
    d.push_back(9'h07F); p.push_back(good_parity(9'h07F, 7, 1));
    for (int k = 0; k < 3; k++) begin
      d.push_back(9'($urandom_range(0, 127)));
      p.push_back(1'($urandom_range(0, 1)));
    end
    foreach (d[k]) begin
      ef.push_back(p[k] != good_parity(d[k], 7, 1));
      send_frame(2, d[k], 7, 1, p[k], 2, 1'b1, 1'b0);
    end
    idle(8);
    foreach (d[k]) begin
      checks++; if (k >= dq_m.size() || dq_m[k] !== d[k] || fq_m[k] !== ef[k])
        begin errors++; $display("FAIL mode7o2_word[%0d]: got %h/%b expected %h/%b", k,
          (k < dq_m.size()) ? dq_m[k] : 9'h1FF, (k < fq_m.size()) ? fq_m[k] : 1'bx, d[k], ef[k]); end
    end
    clear_mon();
    send_frame(2, 9'h015, 7, 1, good_parity(9'h015, 7, 1), 2, 1'b0, 1'b0);
    @(negedge clk_in); rx_m = 1'b1;
    idle(40);
    checks++; if (fe_n[2] != 1 || dq_m.size() != 0)
      begin errors++; $display("FAIL mode7o2_stop2: ferr %0d words %0d expected 1 0", fe_n[2], dq_m.size()); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    set_ready(1'b0);
    send_frame(0, 9'h096, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    idle(4);
    checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", vld_a); end
    for (int c = 0; c < 16 * 3 + 8; c++) begin @(negedge clk_in); rx_a = 1'b0; end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b expected 1", busy_a); end
    @(negedge clk_in); rst_n = 1'b0; rx_a = 1'b1;
    @(negedge clk_in); rst_n = 1'b1;
    checks++; if (vld_a !== 1'b0 || dat_a !== 8'h00 || perr_a !== 1'b0)
      begin errors++; $display("FAIL rstmid_outputs: valid %b data %h perr %b expected 0 00 0", vld_a, dat_a, perr_a); end
    checks++; if (busy_a !== 1'b0 || ferr_a !== 1'b0 || ovr_a !== 1'b0)
      begin errors++; $display("FAIL rstmid_status: busy %b ferr %b ovr %b expected 0 0 0", busy_a, ferr_a, ovr_a); end
    set_ready(1'b1);
    idle(48);
    checks++; if (dq_a.size() != 0 || fe_n[0] != 0)
      begin errors++; $display("FAIL rstmid_partial: words %0d ferr %0d expected 0 0", dq_a.size(), fe_n[0]); end
    send_frame(0, 9'h0C3, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    idle(8);
    checks++; if (dq_a.size() != 1 || dq_a[0] !== 9'h0C3)
      begin errors++; $display("FAIL rstmid_next: got %0d words, first %h, expected c3", dq_a.size(), (dq_a.size() > 0) ? dq_a[0] : 9'h1FF); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_noise();
    test_framing();
    test_overrun();
    test_modes();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
